mips_lsu: RTL
=============

Name: mips_lsu

Overview:
Parametrised load/store unit between the MIPS datapath memory stage and the data memory port. It replaces fixed 32-bit, zero-wait byte-enable generation with the following:
- width-generic byte-enable and write-data lane steering;
- load extraction with sign or zero extension;
- misalignment detection;
- a req/ack memory handshake with arbitrary wait states, stalling the pipeline while the access is outstanding.

Parameters:
DATA_W, 32, memory data width in bits; legal values 32 or 64.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  memory stage requests an access; held stable while stall=1.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W=64).
req_signed  in  1  sign-extend load result.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-aligned.
stall  out  1  freeze the pipeline.
rdata  out  DATA_W  extended load result.
rdata_valid  out  1  one-cycle pulse when rdata is updated.
addr_err  out  1  misaligned request (exception pulse).
badvaddr  out  ADDR_W  faulting address, valid when addr_err=1.
mem_req  out  1  memory request.
mem_we  out  1  memory write.
mem_addr  out  ADDR_W  req_addr with the low log2(DATA_W/8) bits cleared.
mem_wen  out  DATA_W/8  byte write enables; 0 for loads.
mem_wdata  out  DATA_W  lane-steered store data.
mem_ack  in  1  memory completes the access (read data valid this cycle).
mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset: state=IDLE; mem_req, mem_we, mem_wen, mem_addr, mem_wdata, rdata, rdata_valid = 0. Combinational outputs are 0 while req_valid=0.
- Reset mid-access drops mem_req immediately. An mem_ack arriving after reset, or in IDLE/DONE, is ignored.
- Lanes are little-endian. off = req_addr[log2(DATA_W/8)-1:0].
- Alignment rules:
  - byte: always aligned.
  - half: addr[0]=0.
  - word: addr[1:0]=0.
  - dword: addr[2:0]=0 and DATA_W=64. size=3 with DATA_W=32 is always misaligned.
- Misaligned request (IDLE, req_valid=1):
  - addr_err=1 and badvaddr=req_addr, combinationally, same cycle.
  - No memory access; stall=0; state stays IDLE.
- Byte enables:
  - byte: 1<<off.
  - half: 2'b11<<off.
  - word: 4'hF<<off.
  - dword: all ones.
- Store data: the low 8/16/32 bits are replicated across all lanes; full DATA_W for dword.
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE: aligned req_valid drives stall=1 combinationally. At the edge: mem_req/mem_we/mem_addr/mem_wen/mem_wdata are registered; off, size and signed are captured; go to BUSY.
  - BUSY: stall=1; outputs held stable until mem_ack=1 is sampled.
    - On ack for a load: rdata <= (mem_rdata >> off*8), masked to the access size, sign- or zero-extended to DATA_W.
    - On ack: rdata_valid <= load; mem_req, mem_we and mem_wen <= 0; go to DONE.
  - DONE: stall=0 so the pipeline advances. rdata_valid=1 for loads. req_valid this cycle belongs to the finished op and is ignored. rdata_valid clears; go to IDLE.
- Latency: accepted in cycle T; mem_req high from T+1; ack at T+1+W (W ≥ 0 wait cycles); DONE at T+2+W. Stall is asserted T..T+1+W.
- Minimum spacing between back-to-back accesses is 3 cycles.
- Stores never pulse rdata_valid; rdata holds its previous value.
- mem_ack while mem_req=0 has no effect.

Test Plan:
1. DATA_W=32. Store byte: addr=0x1003, wdata=0xAB, ack with 0 waits → mem_addr=0x1000, mem_wen=4'b1000, mem_wdata=0xABABABAB; stall high 2 cycles, low in DONE.
2. Load half, signed, addr=0x2002; mem_rdata=0x8001_1234; ack after 3 wait cycles → rdata=0xFFFF8001, rdata_valid pulses once in DONE; stall high 5 cycles. Repeat unsigned → rdata=0x00008001.
3. Misaligned word load at addr=0x3001 → addr_err=1 and badvaddr=0x3001 the same cycle; mem_req never asserts; stall=0. size=3 at DATA_W=32 → addr_err.
4. DATA_W=64. Load dword at addr=0x8 → mem_wen=0, rdata=mem_rdata. Load word signed at addr=0xC with mem_rdata=0x9000_0000_xxxx_xxxx → rdata=0xFFFFFFFF90000000.
5. Assert rst while in BUSY with mem_req=1 → mem_req=0 immediately, state IDLE. A late mem_ack produces no rdata_valid; the next request completes normally.
6. Back-to-back load then store with req_valid held continuously → second mem_req rises exactly 3 cycles after the first (0-wait memory). The DONE cycle does not start a duplicate access.

Source files
------------

// File: rtl/mips_lsu.sv
// Load/store unit between the MIPS memory stage and a req/ack data memory port.
// Steers byte lanes, extends loads, flags misaligned accesses and stalls while busy.
module mips_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  stall,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_valid,
  output logic                  addr_err,
  output logic [ADDR_W-1:0]     badvaddr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [NB-1:0]       mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic [OFFW-1:0]     off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;

  logic                aligned_s, accept_s, err_s;
  logic [OFFW-1:0]     off_s;
  logic [NB-1:0]       wen_s;
  logic [DATA_W-1:0]   wdata_s, shifted_s, left_s, ext_s;
  logic [6:0]          lsh_s;

  assign off_s = req_addr[OFFW-1:0];

  // Alignment check, byte enables and replicated store data for the request
  always_comb begin
    aligned_s = 1'b0;
    wen_s     = {NB{1'b0}};
    wdata_s   = {DATA_W{1'b0}};
    case (req_size)
      2'd0: begin
        aligned_s = 1'b1;
        wen_s     = NB'(1'b1) << off_s;
        wdata_s   = {NB{req_wdata[7:0]}};
      end
      2'd1: begin
        aligned_s = (req_addr[0] == 1'b0);
        wen_s     = NB'(2'b11) << off_s;
        wdata_s   = {(NB/2){req_wdata[15:0]}};
      end
      2'd2: begin
        aligned_s = (req_addr[1:0] == 2'b00);
        wen_s     = NB'(4'hF) << off_s;
        wdata_s   = {(NB/4){req_wdata[31:0]}};
      end
      2'd3: begin
        aligned_s = (DATA_W == 64) && (req_addr[2:0] == 3'b000);
        wen_s     = {NB{1'b1}};
        wdata_s   = req_wdata;
      end
      default: begin
        aligned_s = 1'b0;
      end
    endcase
  end

  assign accept_s    = (state_q == IDLE) && req_valid && aligned_s;
  assign err_s       = (state_q == IDLE) && req_valid && !aligned_s;
  assign stall       = accept_s || (state_q == BUSY);
  assign addr_err    = err_s;
  assign badvaddr    = err_s ? req_addr : {ADDR_W{1'b0}};

  // Load extraction: left-justify the field, then shift back arithmetically or logically
  always_comb begin
    shifted_s = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    lsh_s = 7'(DATA_W - 8);
      2'd1:    lsh_s = 7'(DATA_W - 16);
      2'd2:    lsh_s = 7'(DATA_W - 32);
      2'd3:    lsh_s = 7'd0;
      default: lsh_s = 7'd0;
    endcase
    left_s = shifted_s << lsh_s;
    if (signed_q) begin
      ext_s = DATA_W'($signed(left_s) >>> lsh_s);
    end else begin
      ext_s = left_s >> lsh_s;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wen_d     = mem_wen_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
    off_d         = off_q;
    size_d        = size_q;
    signed_d      = signed_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
          mem_wen_d   = req_we ? wen_s : {NB{1'b0}};
          mem_wdata_d = wdata_s;
          off_d       = off_s;
          size_d      = req_size;
          signed_d    = req_signed;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            rdata_d = ext_s;
          end else begin
            rdata_d = rdata_q;
          end
          rdata_valid_d = !mem_we_q;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          mem_wen_d     = {NB{1'b0}};
          state_d       = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        // Any req_valid seen here still belongs to the op that just finished
        rdata_valid_d = 1'b0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_wen_q     <= {NB{1'b0}};
      mem_wdata_q   <= {DATA_W{1'b0}};
      rdata_q       <= {DATA_W{1'b0}};
      rdata_valid_q <= 1'b0;
      off_q         <= {OFFW{1'b0}};
      size_q        <= 2'd0;
      signed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wen_q     <= mem_wen_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      off_q         <= off_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wen     = mem_wen_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
